control_secuencia_cmd: RTL
==========================

// Module: control_secuencia_cmd
// PURPOSE
//  Command-layer sequencer that drives the CMD physical-layer controller.
//  Latches a host command (index, argument, no-response flag) and computes CRC7 serially.
//  Builds the 48-bit SD command frame for the P-S wrapper, then runs the strobe/ack
//  handshake with the physical layer. Also handles timeout/abort and returns the
//  response to the register block.
// PARAMETERS
//  RESP_W        15    width of response word passed through from the physical layer
//  WATCHDOG_CYC  1024  sd_clock cycles allowed in WAIT_RESP+WAIT_ACK before forced abort
//  MAX_RETRY     2     re-issues after a timeout (used only with CMD_RETRY_EN)
// PORTS
//  sd_clock         in   1       clock; all logic on posedge
//  reset            in   1       asynchronous, active-low reset
//  cmd_start        in   1       start request; sampled only in IDLE
//  cmd_index        in   6       command index, latched on accepted cmd_start
//  cmd_argument     in   32      command argument, latched on accepted cmd_start
//  cmd_no_response  in   1       command expects no response, latched with start
//  cmd_abort        in   1       abort current command (any state except IDLE)
//  cmd_busy         out  1       high from accept until DONE exits
//  cmd_done         out  1       1-cycle pulse at end of every command (ok/err/abort)
//  cmd_response     out  RESP_W  response captured from physical layer, held until next start
//  cmd_timeout_err  out  1       set with cmd_done on timeout/watchdog; cleared on next accept
//  cmd_frame        out  48      {0,1,index,argument,crc7,1}; stable from REQ until IDLE
//  phy_strobe       out  1       to physical-layer strobe_in
//  phy_ack          out  1       to physical-layer ack_in
//  phy_idle         out  1       to physical-layer idle_in (forces it to idle)
//  phy_no_response  out  1       to physical-layer no_response (= latched flag while busy)
//  phy_strobe_in    in   1       physical-layer strobe_out (response ready)
//  phy_ack_in       in   1       physical-layer ack_out (handshake closed)
//  phy_response     in   RESP_W  physical-layer response
//  phy_timeout      in   1       physical-layer command_timeout
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; every output 0 (cmd_frame=0, cmd_response=0); counters 0.
//  States: IDLE, CRC, REQ, WAIT_RESP, WAIT_ACK, ABORT, DONE (one-hot, registered).
//  IDLE: cmd_start=1 -> latch inputs, clear cmd_timeout_err, crc=0, bit_cnt=0, go CRC.
//  CRC: one bit per cycle, MSB first, over 40 bits {0,1,index,argument};
//   poly x^7+x^3+1: fb=bit^crc[6]; crc={crc[5:3],crc[2]^fb,crc[1:0],fb}.
//   bit_cnt==39 -> cmd_frame loaded, go REQ. CRC takes exactly 40 cycles.
//  REQ: phy_strobe=1 for exactly 1 cycle; watchdog cleared; go WAIT_RESP.
//   Latency: accept at cycle 0 -> phy_strobe high in cycle 41.
//  WAIT_RESP: phy_strobe_in=1 -> cmd_response<=phy_response, go WAIT_ACK.
//   phy_timeout=1 or watchdog==WATCHDOG_CYC-1 -> cmd_timeout_err=1, go ABORT.
//   phy_strobe_in and phy_timeout in the same cycle -> timeout wins; response is not captured.
//  WAIT_ACK: phy_ack=1 held until phy_ack_in=1, then go DONE. Watchdog still runs;
//   expiry -> ABORT with cmd_timeout_err=1.
//  ABORT: phy_idle=1 for 1 cycle, phy_strobe/phy_ack=0, go DONE.
//  DONE: cmd_done=1 for 1 cycle, cmd_busy=0 next cycle, go IDLE. cmd_start in DONE is ignored.
//  cmd_abort=1 in CRC/REQ/WAIT_RESP/WAIT_ACK -> ABORT next cycle (cmd_timeout_err unchanged).
//   cmd_abort has priority over every other transition; it is ignored in IDLE/ABORT/DONE.
//  Watchdog: counts each cycle in WAIT_RESP/WAIT_ACK, saturates, cleared in REQ.
//  reset mid-command: immediate return to IDLE with all outputs 0; no phy_idle pulse.
// CONFIGURATION
//  CMD_RETRY_EN defined: a timeout (phy_timeout or watchdog) with retry_cnt<MAX_RETRY
//   -> phy_idle 1 cycle, retry_cnt+1, back to REQ. No CRC recompute; cmd_frame is unchanged.
//   cmd_timeout_err is set only when retries are exhausted. retry_cnt is cleared on accept.
//  CMD_RETRY_EN undefined: the first timeout goes to ABORT; MAX_RETRY is unused.
// TESTING
//  CMD0 arg 0x00000000 -> crc 0x4A, cmd_frame=48'h400000000095, phy_strobe at cycle 41.
//  CMD8 arg 0x000001AA, phy_strobe_in 5 cycles later with resp 0x1234 -> cmd_response=0x1234,
//   phy_ack held until phy_ack_in, then cmd_done pulse with cmd_timeout_err=0.
//  CMD17 arg 0 -> cmd_frame=48'h510000000055; phy_timeout in WAIT_RESP -> phy_idle pulse,
//   cmd_done with cmd_timeout_err=1 (CMD_RETRY_EN: 2 re-strobes first, then error).
//  No phy_strobe_in for WATCHDOG_CYC cycles -> abort path, cmd_timeout_err=1.
//  cmd_abort in CRC cycle 10; reset low during WAIT_ACK -> all outputs 0 immediately.
//  cmd_start held high through DONE -> exactly one command per IDLE acceptance.

Source files
------------

// File: rtl/control_secuencia_cmd_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_secuencia_cmd_if
//  Description : Host-side and physical-layer-side signal bundle for the CMD
//                sequencer. The sequencer connects through the slave
//                modport. The host/PHY side connects through the master
//                modport.
//  Parameters  : RESP_W - width of the response word
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_secuencia_cmd_if #(
  parameter int RESP_W = 15
);
  // host command request
  logic              cmd_start;
  logic [5:0]        cmd_index;
  logic [31:0]       cmd_argument;
  logic              cmd_no_response;
  logic              cmd_abort;
  // host status / result
  logic              cmd_busy;
  logic              cmd_done;
  logic [RESP_W-1:0] cmd_response;
  logic              cmd_timeout_err;
  logic [47:0]       cmd_frame;
  // towards the physical layer
  logic              phy_strobe;
  logic              phy_ack;
  logic              phy_idle;
  logic              phy_no_response;
  // from the physical layer
  logic              phy_strobe_in;
  logic              phy_ack_in;
  logic [RESP_W-1:0] phy_response;
  logic              phy_timeout;

  modport slave (
    input  cmd_start, cmd_index, cmd_argument, cmd_no_response, cmd_abort,
    input  phy_strobe_in, phy_ack_in, phy_response, phy_timeout,
    output cmd_busy, cmd_done, cmd_response, cmd_timeout_err, cmd_frame,
    output phy_strobe, phy_ack, phy_idle, phy_no_response
  );

  modport master (
    output cmd_start, cmd_index, cmd_argument, cmd_no_response, cmd_abort,
    output phy_strobe_in, phy_ack_in, phy_response, phy_timeout,
    input  cmd_busy, cmd_done, cmd_response, cmd_timeout_err, cmd_frame,
    input  phy_strobe, phy_ack, phy_idle, phy_no_response
  );
endinterface
`default_nettype wire

// File: rtl/control_secuencia_cmd.sv
`default_nettype none
// ============================================================================
//  Module      : control_secuencia_cmd
//  Description : Command-layer sequencer for the SD CMD line. It latches a
//                host command and computes its CRC7 serially, one bit per
//                cycle. It then builds the 48-bit frame and runs the
//                strobe/ack handshake with the physical layer. It also
//                handles timeout, watchdog and abort, and returns the
//                captured response.
//  Ports       : sd_clock - clock, all logic on rising edge
//                reset    - asynchronous active-low reset
//                bus      - control_secuencia_cmd_if.slave:
//                  host side : cmd_start/index/argument/no_response/abort in;
//                              cmd_busy/done/response/timeout_err/frame out
//                  PHY side  : phy_strobe/ack/idle/no_response out;
//                              phy_strobe_in/ack_in/response/timeout in
//  Macro       : CMD_RETRY_EN - when defined, a timeout re-issues the frame.
//                The frame is re-issued up to MAX_RETRY times before an
//                error is reported.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_secuencia_cmd #(
  parameter int RESP_W       = 15,
  parameter int WATCHDOG_CYC = 1024,
  parameter int MAX_RETRY    = 2
) (
  input  wire logic              sd_clock,
  input  wire logic              reset,
  control_secuencia_cmd_if.slave bus
);

  localparam int WD_W = $clog2(WATCHDOG_CYC) + 1;

  typedef enum logic [6:0] {
    S_IDLE      = 7'b000_0001,
    S_CRC       = 7'b000_0010,
    S_REQ       = 7'b000_0100,
    S_WAIT_RESP = 7'b000_1000,
    S_WAIT_ACK  = 7'b001_0000,
    S_ABORT     = 7'b010_0000,
    S_DONE      = 7'b100_0000
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        crc_q, crc_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [5:0]        idx_q, idx_d;
  logic [31:0]       arg_q, arg_d;
  logic              nores_q, nores_d;
  logic [47:0]       frame_q, frame_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic              terr_q, terr_d;

`ifdef CMD_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  // set when the current ABORT pass is a retry and must return to REQ
  logic               retry_pend_q, retry_pend_d;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MAX_RETRY >= 0);
`endif

  logic [39:0] w_msg;
  logic        w_fb;
  logic [6:0]  w_crc_next;
  logic        w_wd_expired;
  logic        w_abort;
  logic        w_to;

  // Frame body without CRC: start bit 0, transmission bit 1, index, argument.
  assign w_msg        = {2'b01, idx_q, arg_q};
  assign w_fb         = w_msg[6'd39 - bit_cnt_q] ^ crc_q[6];
  assign w_crc_next   = {crc_q[5:3], crc_q[2] ^ w_fb, crc_q[1:0], w_fb};
  assign w_wd_expired = (wd_q == WD_W'(WATCHDOG_CYC - 1));
  assign w_abort      = bus.cmd_abort &&
                        ((state_q == S_CRC) || (state_q == S_REQ) ||
                         (state_q == S_WAIT_RESP) || (state_q == S_WAIT_ACK));

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    bit_cnt_d = bit_cnt_q;
    wd_d      = wd_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    nores_d   = nores_q;
    frame_d   = frame_q;
    resp_d    = resp_q;
    terr_d    = terr_q;
    w_to      = 1'b0;
`ifdef CMD_RETRY_EN
    retry_cnt_d  = retry_cnt_q;
    retry_pend_d = retry_pend_q;
`endif

    // The watchdog spans both wait states and saturates instead of wrapping.
    if (((state_q == S_WAIT_RESP) || (state_q == S_WAIT_ACK)) && !(&wd_q)) begin
      wd_d = wd_q + WD_W'(1);
    end

    if (w_abort) begin
      state_d = S_ABORT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_start) begin
            idx_d     = bus.cmd_index;
            arg_d     = bus.cmd_argument;
            nores_d   = bus.cmd_no_response;
            terr_d    = 1'b0;
            crc_d     = 7'd0;
            bit_cnt_d = 6'd0;
`ifdef CMD_RETRY_EN
            retry_cnt_d  = '0;
            retry_pend_d = 1'b0;
`endif
            state_d   = S_CRC;
          end
        end
        S_CRC: begin
          crc_d     = w_crc_next;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd39) begin
            // the last bit's CRC is taken combinationally so the frame is ready at REQ
            frame_d = {w_msg, w_crc_next, 1'b1};
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          wd_d    = '0;
          state_d = S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          // a timeout in the same cycle as a response wins and drops the response
          if (bus.phy_timeout || w_wd_expired) begin
            w_to = 1'b1;
          end else if (bus.phy_strobe_in) begin
            resp_d  = bus.phy_response;
            state_d = S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (w_wd_expired) begin
            w_to = 1'b1;
          end else if (bus.phy_ack_in) begin
            state_d = S_DONE;
          end
        end
        S_ABORT: begin
`ifdef CMD_RETRY_EN
          if (retry_pend_q) begin
            retry_pend_d = 1'b0;
            state_d      = S_REQ;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (w_to) begin
      state_d = S_ABORT;
`ifdef CMD_RETRY_EN
      if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
        retry_cnt_d  = retry_cnt_q + RETRY_W'(1);
        retry_pend_d = 1'b1;
      end else begin
        terr_d = 1'b1;
      end
`else
      terr_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      crc_q     <= 7'd0;
      bit_cnt_q <= 6'd0;
      wd_q      <= '0;
      idx_q     <= 6'd0;
      arg_q     <= 32'd0;
      nores_q   <= 1'b0;
      frame_q   <= 48'd0;
      resp_q    <= '0;
      terr_q    <= 1'b0;
`ifdef CMD_RETRY_EN
      retry_cnt_q  <= '0;
      retry_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      bit_cnt_q <= bit_cnt_d;
      wd_q      <= wd_d;
      idx_q     <= idx_d;
      arg_q     <= arg_d;
      nores_q   <= nores_d;
      frame_q   <= frame_d;
      resp_q    <= resp_d;
      terr_q    <= terr_d;
`ifdef CMD_RETRY_EN
      retry_cnt_q  <= retry_cnt_d;
      retry_pend_q <= retry_pend_d;
`endif
    end
  end

  // Handshake outputs decode straight from the registered one-hot state.
  assign bus.cmd_busy        = (state_q != S_IDLE);
  assign bus.cmd_done        = (state_q == S_DONE);
  assign bus.cmd_response    = resp_q;
  assign bus.cmd_timeout_err = terr_q;
  assign bus.cmd_frame       = frame_q;
  assign bus.phy_strobe      = (state_q == S_REQ);
  assign bus.phy_ack         = (state_q == S_WAIT_ACK);
  assign bus.phy_idle        = (state_q == S_ABORT);
  assign bus.phy_no_response = (state_q != S_IDLE) && nores_q;

endmodule
`default_nettype wire
